rf_wb_arbiter: RTL and testbench

//   Shares the register file's single write port between two writeback sources
//   (ALU and MEM). Each source has a small FIFO and a valid/ready handshake.

---
 rtl/rf_pkg.sv | 18 +
 rtl/wb_fifo.sv | 65 ++++++
 rtl/rf_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Writeback types shared by the register file, the writeback stage and the
// write-port arbiter.
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of writeback requests. Every entry's address and
// occupancy are exposed so the owner can build a pending-write mask.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] ent_vld,
  output logic [RF_AW-1:0] ent_addr [DEPTH]
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  wb_req_t       store [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = store[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_req;
  end

  // An entry is live when its distance from the read pointer is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] off;
    assign off         = PW'(g) - rd_ptr;
    assign ent_vld[g]  = ({1'b0, off} < count);
    assign ent_addr[g] = store[g].addr;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// the ALU and MEM writeback sources, with a pending-write mask for decode.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_addr,
  input  logic [DW-1:0]     alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_data,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic              grant_src,
  output logic [2**AW-1:0]  pending_mask,
  output logic [CW-1:0]     wr_cnt
);

  logic             rdy_en;
  wb_src_e          last_grant;

  wb_req_t          alu_head, mem_head;
  logic             alu_full, alu_empty, mem_full, mem_empty;
  logic [DEPTH-1:0] alu_vld, mem_vld;
  logic [AW-1:0]    alu_ent [DEPTH];
  logic [AW-1:0]    mem_ent [DEPTH];

  logic             gnt_vld_p0;
  wb_src_e          gnt_src_p0;
  wb_req_t          gnt_req_p0;
  logic             alu_pop, mem_pop;

  // Ready is held low through reset and comes up on the first edge after release.
  assign alu_ready = rdy_en && !alu_full;
  assign mem_ready = rdy_en && !mem_full;

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (alu_valid && alu_ready),
    .push_req ('{addr: alu_addr, data: alu_data}),
    .pop      (alu_pop),
    .head     (alu_head),
    .full     (alu_full),
    .empty    (alu_empty),
    .ent_vld  (alu_vld),
    .ent_addr (alu_ent)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (mem_valid && mem_ready),
    .push_req ('{addr: mem_addr, data: mem_data}),
    .pop      (mem_pop),
    .head     (mem_head),
    .full     (mem_full),
    .empty    (mem_empty),
    .ent_vld  (mem_vld),
    .ent_addr (mem_ent)
  );

  // Stage p0: pick a winner among non-empty FIFOs, favouring the source not granted last.
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_src_p0 = SRC_ALU;
    if (!alu_empty && !mem_empty) begin
      gnt_vld_p0 = 1'b1;
      gnt_src_p0 = (last_grant == SRC_MEM) ? SRC_ALU : SRC_MEM;
    end else if (!alu_empty) begin
      gnt_vld_p0 = 1'b1;
      gnt_src_p0 = SRC_ALU;
    end else if (!mem_empty) begin
      gnt_vld_p0 = 1'b1;
      gnt_src_p0 = SRC_MEM;
    end
    gnt_req_p0 = (gnt_src_p0 == SRC_MEM) ? mem_head : alu_head;
  end

  assign alu_pop = gnt_vld_p0 && (gnt_src_p0 == SRC_ALU);
  assign mem_pop = gnt_vld_p0 && (gnt_src_p0 == SRC_MEM);

  // Stage p1: register the granted write; r0 consumes a grant but never asserts rf_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en     <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      grant_src  <= 1'b0;
      last_grant <= SRC_MEM;
      wr_cnt     <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (rf_we) wr_cnt <= wr_cnt + 1'b1;
      rf_we <= gnt_vld_p0 && (gnt_req_p0.addr != '0);
      if (gnt_vld_p0) begin
        rf_waddr   <= gnt_req_p0.addr;
        rf_wdata   <= gnt_req_p0.data;
        grant_src  <= gnt_src_p0;
        last_grant <= gnt_src_p0;
      end
    end
  end

  // Pending mask: every live buffered address plus the write currently on the port.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_vld[i]) pending_mask[alu_ent[i]] = 1'b1;
      if (mem_vld[i]) pending_mask[mem_ent[i]] = 1'b1;
    end
    if (rf_we) pending_mask[rf_waddr] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a table of single writes plus
// hand-written multi-cycle sequences for arbitration, reset and wrap.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        grant_src;
  logic [31:0] pending_mask;
  logic [15:0] wr_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.AW(5), .DW(32), .DEPTH(2), .CW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .grant_src    (grant_src),
    .pending_mask (pending_mask),
    .wr_cnt       (wr_cnt)
  );

  typedef struct {
    bit          src;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_mask;
    bit          exp_we;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    step();
  endtask

  // One isolated write from the given source, checked through its whole lifetime.
  task automatic check_write(input bit src, input logic [4:0] a, input logic [31:0] d,
                             input logic [31:0] exp_mask, input bit exp_we);
    logic [15:0] base;
    base = wr_cnt;
    chk("src_ready", src ? mem_ready : alu_ready, 1);
    if (src) begin mem_valid = 1'b1; mem_addr = a; mem_data = d; end
    else     begin alu_valid = 1'b1; alu_addr = a; alu_data = d; end
    step();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    chk("mask_buffered", pending_mask, exp_mask);
    chk("we_latency", rf_we, 0);
    step();
    chk("rf_we", rf_we, exp_we);
    chk("rf_waddr", rf_waddr, a);
    chk("rf_wdata", rf_wdata, d);
    chk("grant_src", grant_src, src);
    chk("mask_on_port", pending_mask, exp_mask);
    step();
    chk("we_one_cycle", rf_we, 0);
    chk("mask_cleared", pending_mask, 0);
    chk("wr_cnt_step", wr_cnt, 16'(base + 16'(exp_we)));
  endtask

  initial begin
    int n;
    int cyc;
    logic [15:0] base;

    vecs[0] = '{src: 1'b0, addr: 5'd5,  data: 32'hDEADBEEF, exp_mask: 32'h0000_0020, exp_we: 1'b1};
    vecs[1] = '{src: 1'b1, addr: 5'd17, data: 32'h1234_5678, exp_mask: 32'h0002_0000, exp_we: 1'b1};
    vecs[2] = '{src: 1'b1, addr: 5'd0,  data: 32'hCAFE_0000, exp_mask: 32'h0000_0000, exp_we: 1'b0};
    vecs[3] = '{src: 1'b0, addr: 5'd31, data: 32'h0000_0001, exp_mask: 32'h8000_0000, exp_we: 1'b1};
    vecs[4] = '{src: 1'b0, addr: 5'd0,  data: 32'hFFFF_FFFF, exp_mask: 32'h0000_0000, exp_we: 1'b0};
    vecs[5] = '{src: 1'b1, addr: 5'd1,  data: 32'hA5A5_5A5A, exp_mask: 32'h0000_0002, exp_we: 1'b1};

    alu_valid = 0; mem_valid = 0;
    alu_addr = 0; mem_addr = 0; alu_data = 0; mem_data = 0;

    // Reset held 3 cycles; check state right after release and one cycle on.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_grant", grant_src, 0);
    chk("rst_cnt", wr_cnt, 0);
    chk("rst_mask", pending_mask, 0);
    chk("rst_alu_ready_low", alu_ready, 0);
    step();
    chk("alu_ready_up", alu_ready, 1);
    chk("mem_ready_up", mem_ready, 1);

    // Table of isolated writes.
    for (int i = 0; i < 6; i++)
      check_write(vecs[i].src, vecs[i].addr, vecs[i].data, vecs[i].exp_mask, vecs[i].exp_we);

    // Both sources push two writes in the same cycles.
    do_reset(1);
    alu_valid = 1; alu_addr = 1; alu_data = 32'h11;
    mem_valid = 1; mem_addr = 3; mem_data = 32'h33;
    step();
    alu_addr = 2; alu_data = 32'h22;
    mem_addr = 4; mem_data = 32'h44;
    step();
    alu_valid = 0; mem_valid = 0;
    chk("rr1_addr", rf_waddr, 1);
    chk("rr1_src", grant_src, 0);
    chk("rr1_mask", pending_mask, 32'h1E);
    chk("rr1_mem_ready", mem_ready, 0);
    chk("rr1_alu_ready", alu_ready, 1);
    step();
    chk("rr2_addr", rf_waddr, 3);
    chk("rr2_src", grant_src, 1);
    chk("rr2_mem_ready", mem_ready, 1);
    step();
    chk("rr3_addr", rf_waddr, 2);
    chk("rr3_data", rf_wdata, 32'h22);
    step();
    chk("rr4_addr", rf_waddr, 4);
    chk("rr4_we", rf_we, 1);
    step();
    chk("rr_idle", rf_we, 0);
    chk("rr_cnt", wr_cnt, 4);

    // MEM r0 alongside ALU r7 (last grant was MEM, so ALU goes first).
    base = wr_cnt;
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    mem_valid = 1; mem_addr = 0; mem_data = 32'h99;
    step();
    alu_valid = 0; mem_valid = 0;
    step();
    chk("r7_we", rf_we, 1);
    chk("r7_addr", rf_waddr, 7);
    step();
    chk("r0_we", rf_we, 0);
    chk("r0_src", grant_src, 1);
    chk("r0_addr", rf_waddr, 0);
    chk("r0_data", rf_wdata, 32'h99);
    step();
    chk("r0_cnt", wr_cnt, 16'(base + 16'd1));

    // Fill both FIFOs, then a single-cycle reset discards everything.
    alu_valid = 1; alu_addr = 10; mem_valid = 1; mem_addr = 12;
    step();
    alu_addr = 11; mem_addr = 13;
    step();
    alu_valid = 0; mem_valid = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_mask", pending_mask, 0);
    step();
    chk("post_rst_we", rf_we, 0);
    chk("post_rst_mask", pending_mask, 0);
    step();
    chk("post_rst_we2", rf_we, 0);
    check_write(1'b0, 5'd5, 32'hDEADBEEF, 32'h0000_0020, 1'b1);
    chk("post_rst_cnt", wr_cnt, 1);

    // Counter wrap: 65535 writes, then one more.
    do_reset(1);
    n = 0;
    cyc = 0;
    alu_addr = 9;
    while (n < 65535 && cyc < 70000) begin
      alu_valid = 1'b1;
      alu_data  = n;
      if (alu_ready) n++;
      step();
      cyc++;
    end
    alu_valid = 1'b0;
    chk("wrap_push_budget", n, 65535);
    repeat (4) step();
    chk("cnt_ffff", wr_cnt, 16'hFFFF);
    check_write(1'b0, 5'd9, 32'h0BAD_F00D, 32'h0000_0200, 1'b1);
    chk("cnt_wrap", wr_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
